scale_ctrl: RTL and testbench

SCALE_CTRL -- requirements
Module: scale_ctrl

---
 rtl/scale_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_scale_ctrl.sv | 560 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_ctrl.sv
// -----------------------------------------------------------------------------
// scale_ctrl -- control path of a bilinear image scaler.
//
// Walks the destination frame in raster order, requests source row pairs from
// the line buffer, and issues one set of tap coordinates plus fractions per
// output pixel to the interpolation datapath. Issue is gated by a credit
// counter that mirrors free space in the downstream output FIFO.
//
// Ports
//   p_clk, rst              clock, synchronous active-high reset
//   start / busy / done     frame start pulse, frame in progress, end pulse
//   cfg_src_w/h, cfg_dst_w/h source and destination sizes (sampled at start)
//   cfg_step_x/y            fixed-point source step per output pixel
//   row_req/row_idx/row_rdy line-buffer handshake for rows y0 and y0+1
//   pix_en, pix_x0/x1/y0/y1, dx, dy   datapath issue and tap coordinates
//   fifo_pop                downstream consumed one pixel (returns a credit)
//   line_end, frame_end     qualify the last issue of a line / frame
//
// Build option
//   SCALE_CTRL_EDGE_CLAMP_EN  clamp x1/y1 to the last source column/row and
//                             zero the matching fraction; when undefined the
//                             second tap is always x0+1 / y0+1.
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; cfg sampled on an accepted start
// ROW_REQ| one-cycle row_req for the current output line's top row
// ROW_WAIT| waiting for row_rdy from the line buffer
// RUN    | issuing pixels of the current line while credits remain
// DRAIN  | counting out datapath latency after the frame's last issue
// -----------------------------------------------------------------------------
module scale_ctrl #(
    parameter int SHIFT_BITS = 10,
    parameter int COORD_W    = 11,
    parameter int CREDITS    = 16,
    parameter int PIPE_LAT   = 5
) (
    input  logic                          p_clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic [COORD_W-1:0]            cfg_src_w,
    input  logic [COORD_W-1:0]            cfg_src_h,
    input  logic [COORD_W-1:0]            cfg_dst_w,
    input  logic [COORD_W-1:0]            cfg_dst_h,
    input  logic [COORD_W+SHIFT_BITS-1:0] cfg_step_x,
    input  logic [COORD_W+SHIFT_BITS-1:0] cfg_step_y,
    output logic                          row_req,
    output logic [COORD_W-1:0]            row_idx,
    input  logic                          row_rdy,
    output logic                          pix_en,
    output logic [COORD_W-1:0]            pix_x0,
    output logic [COORD_W-1:0]            pix_x1,
    output logic [COORD_W-1:0]            pix_y0,
    output logic [COORD_W-1:0]            pix_y1,
    output logic [SHIFT_BITS-1:0]         dx,
    output logic [SHIFT_BITS-1:0]         dy,
    input  logic                          fifo_pop,
    output logic                          line_end,
    output logic                          frame_end
);

    localparam int ACC_W = COORD_W + SHIFT_BITS;
    localparam int CRD_W = $clog2(CREDITS + 1);
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_REQ,
        S_ROW_WAIT,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [COORD_W-1:0]   r_src_w, r_src_h, r_dst_w, r_dst_h;
    logic [ACC_W-1:0]     r_step_x, r_step_y;
    logic [ACC_W-1:0]     r_acc_x, r_acc_y;
    logic [COORD_W-1:0]   r_col, r_row;
    logic [CRD_W-1:0]     r_credit;
    logic [DRN_W-1:0]     r_drain_cnt;
    logic                 r_done_zero;

    logic [COORD_W-1:0]   r_pix_x0, r_pix_x1, r_pix_y0, r_pix_y1;
    logic [SHIFT_BITS-1:0] r_dx, r_dy;

    logic                 w_issue;
    logic                 w_last_col;
    logic                 w_last_row;
    logic                 w_drain_tc;
    logic                 w_cfg_zero;
    logic                 w_accept;

    logic [COORD_W-1:0]   w_x0, w_x1, w_y0, w_y1;
    logic [SHIFT_BITS-1:0] w_dx, w_dy;
    logic [COORD_W-1:0]   w_x0_inc, w_y0_inc;

    assign w_issue    = (r_state == S_RUN) && (r_credit != '0);
    assign w_last_col = (r_col == r_dst_w - COORD_W'(1));
    assign w_last_row = (r_row == r_dst_h - COORD_W'(1));
    assign w_drain_tc = (r_state == S_DRAIN) && (r_drain_cnt == '0);
    assign w_cfg_zero = (cfg_dst_w == '0) || (cfg_dst_h == '0);
    assign w_accept   = (r_state == S_IDLE) && start;

    assign w_x0     = r_acc_x[ACC_W-1:SHIFT_BITS];
    assign w_y0     = r_acc_y[ACC_W-1:SHIFT_BITS];
    assign w_x0_inc = w_x0 + COORD_W'(1);
    assign w_y0_inc = w_y0 + COORD_W'(1);

`ifdef SCALE_CTRL_EDGE_CLAMP_EN
    logic w_x_clamp, w_y_clamp;

    // x0+1 >= src_w  <=>  x0+1 would step past the last source column.
    assign w_x_clamp = ({1'b0, w_x0} + (COORD_W+1)'(1)) >= {1'b0, r_src_w};
    assign w_y_clamp = ({1'b0, w_y0} + (COORD_W+1)'(1)) >= {1'b0, r_src_h};
    assign w_x1      = w_x_clamp ? (r_src_w - COORD_W'(1)) : w_x0_inc;
    assign w_y1      = w_y_clamp ? (r_src_h - COORD_W'(1)) : w_y0_inc;
    assign w_dx      = w_x_clamp ? '0 : r_acc_x[SHIFT_BITS-1:0];
    assign w_dy      = w_y_clamp ? '0 : r_acc_y[SHIFT_BITS-1:0];
`else
    // Source sizes only matter for clamping; kept sampled so both builds
    // share the same register set.
    logic w_src_unused;

    assign w_src_unused = ^{r_src_w, r_src_h};
    assign w_x1         = w_x0_inc;
    assign w_y1         = w_y0_inc;
    assign w_dx         = r_acc_x[SHIFT_BITS-1:0];
    assign w_dy         = r_acc_y[SHIFT_BITS-1:0];
`endif

    // Tap outputs show the live coordinates during an issue and hold the
    // last issued set otherwise.
    assign pix_x0  = w_issue ? w_x0 : r_pix_x0;
    assign pix_x1  = w_issue ? w_x1 : r_pix_x1;
    assign pix_y0  = w_issue ? w_y0 : r_pix_y0;
    assign pix_y1  = w_issue ? w_y1 : r_pix_y1;
    assign dx      = w_issue ? w_dx : r_dx;
    assign dy      = w_issue ? w_dy : r_dy;
    assign row_idx = w_y0;

    always_ff @(posedge p_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        row_req     = 1'b0;
        pix_en      = w_issue;
        line_end    = w_issue && w_last_col;
        frame_end   = w_issue && w_last_col && w_last_row;
        // busy falls in the same cycle the drain count expires.
        busy        = (r_state != S_IDLE) && !w_drain_tc;
        done        = w_drain_tc || r_done_zero;

        unique case (r_state)
            S_IDLE: begin
                if (start && !w_cfg_zero) begin
                    w_state_nxt = S_ROW_REQ;
                end
            end
            S_ROW_REQ: begin
                row_req     = 1'b1;
                w_state_nxt = S_ROW_WAIT;
            end
            S_ROW_WAIT: begin
                if (row_rdy) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue && w_last_col) begin
                    w_state_nxt = w_last_row ? S_DRAIN : S_ROW_REQ;
                end
            end
            S_DRAIN: begin
                if (w_drain_tc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (rst) begin
            r_src_w     <= '0;
            r_src_h     <= '0;
            r_dst_w     <= '0;
            r_dst_h     <= '0;
            r_step_x    <= '0;
            r_step_y    <= '0;
            r_acc_x     <= '0;
            r_acc_y     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_credit    <= CRD_W'(CREDITS);
            r_drain_cnt <= '0;
            r_done_zero <= 1'b0;
            r_pix_x0    <= '0;
            r_pix_x1    <= '0;
            r_pix_y0    <= '0;
            r_pix_y1    <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
        end else begin
            // An empty destination finishes immediately without leaving IDLE.
            r_done_zero <= w_accept && w_cfg_zero;

            if (w_accept) begin
                r_src_w  <= cfg_src_w;
                r_src_h  <= cfg_src_h;
                r_dst_w  <= cfg_dst_w;
                r_dst_h  <= cfg_dst_h;
                r_step_x <= cfg_step_x;
                r_step_y <= cfg_step_y;
                r_acc_x  <= '0;
                r_acc_y  <= '0;
                r_col    <= '0;
                r_row    <= '0;
            end

            // Issue and pop in one cycle cancel; pops on a full count are
            // spurious and dropped so the count never exceeds CREDITS.
            case ({w_issue, fifo_pop})
                2'b10: r_credit <= r_credit - CRD_W'(1);
                2'b01: begin
                    if (r_credit != CRD_W'(CREDITS)) begin
                        r_credit <= r_credit + CRD_W'(1);
                    end
                end
                default: ;
            endcase

            if (w_issue) begin
                r_pix_x0 <= w_x0;
                r_pix_x1 <= w_x1;
                r_pix_y0 <= w_y0;
                r_pix_y1 <= w_y1;
                r_dx     <= w_dx;
                r_dy     <= w_dy;
                if (w_last_col) begin
                    r_col   <= '0;
                    r_acc_x <= '0;
                    r_row   <= r_row + COORD_W'(1);
                    r_acc_y <= r_acc_y + r_step_y;
                end else begin
                    r_col   <= r_col + COORD_W'(1);
                    r_acc_x <= r_acc_x + r_step_x;
                end
            end

            // The cycle after the last issue is drain cycle 1 of PIPE_LAT.
            if (w_issue && w_last_col && w_last_row) begin
                r_drain_cnt <= DRN_W'(PIPE_LAT - 1);
            end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - DRN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_scale_ctrl.sv
module tb_scale_ctrl;

    localparam int SB = 10;
    localparam int CW = 11;
    localparam int CR = 16;
    localparam int PL = 5;
    localparam longint ACC_MOD = longint'(1) << (CW + SB);

`ifdef SCALE_CTRL_EDGE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] x0;
        logic [CW-1:0] x1;
        logic [CW-1:0] y0;
        logic [CW-1:0] y1;
        logic [SB-1:0] dx;
        logic [SB-1:0] dy;
        logic          le;
        logic          fe;
    } pix_t;

    logic          p_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic [CW-1:0] cfg_src_w = '0, cfg_src_h = '0, cfg_dst_w = '0, cfg_dst_h = '0;
    logic [CW+SB-1:0] cfg_step_x = '0, cfg_step_y = '0;
    logic          row_req;
    logic [CW-1:0] row_idx;
    logic          row_rdy = 1'b1;
    logic          pix_en;
    logic [CW-1:0] pix_x0, pix_x1, pix_y0, pix_y1;
    logic [SB-1:0] dx, dy;
    logic          fifo_pop = 1'b0;
    logic          line_end, frame_end;

    always #5 p_clk = ~p_clk;

    scale_ctrl #(
        .SHIFT_BITS(SB),
        .COORD_W   (CW),
        .CREDITS   (CR),
        .PIPE_LAT  (PL)
    ) dut (
        .p_clk     (p_clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cfg_src_w (cfg_src_w),
        .cfg_src_h (cfg_src_h),
        .cfg_dst_w (cfg_dst_w),
        .cfg_dst_h (cfg_dst_h),
        .cfg_step_x(cfg_step_x),
        .cfg_step_y(cfg_step_y),
        .row_req   (row_req),
        .row_idx   (row_idx),
        .row_rdy   (row_rdy),
        .pix_en    (pix_en),
        .pix_x0    (pix_x0),
        .pix_x1    (pix_x1),
        .pix_y0    (pix_y0),
        .pix_y1    (pix_y1),
        .dx        (dx),
        .dy        (dy),
        .fifo_pop  (fifo_pop),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    logic [80:0] all_out;
    assign all_out = {busy, done, row_req, pix_en, line_end, frame_end, row_idx,
                      pix_x0, pix_x1, pix_y0, pix_y1, dx, dy};

    int checks = 0;
    int failures = 0;

    // background drivers (line buffer and downstream consumer)
    bit rdy_auto = 1'b0;
    bit rdy_manual = 1'b1;
    int rdy_max = 0;
    bit pop_rand = 1'b0;
    bit pop_manual = 1'b1;

    initial begin
        int rdy_wait;
        rdy_wait = 0;
        forever begin
            @(posedge p_clk);
            #2;
            if (!rdy_auto) begin
                row_rdy = rdy_manual;
            end else if (row_req) begin
                row_rdy  = 1'b0;
                rdy_wait = $urandom_range(0, rdy_max);
            end else if (rdy_wait > 0) begin
                rdy_wait--;
            end else begin
                row_rdy = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge p_clk);
            #2;
            fifo_pop = pop_rand ? 1'($urandom_range(0, 1)) : pop_manual;
        end
    end

    // monitor: records issues, row requests, done pulses and FIFO occupancy
    pix_t got_q[$];
    int   got_rq[$];
    int   cyc = 0;
    int   issue_cnt = 0;
    int   done_cnt = 0;
    int   row_req_cnt = 0;
    int   last_issue_cyc = 0;
    int   done_cyc = 0;
    logic busy_at_done = 1'b0;
    logic busy_before_done = 1'b0;
    logic busy_last = 1'b0;
    int   occ = 0;
    int   viol = 0;

    initial begin
        pix_t p;
        forever begin
            @(negedge p_clk);
            cyc++;
            if (pix_en === 1'b1) begin
                if (occ >= CR) viol++;
                p.x0 = pix_x0; p.x1 = pix_x1; p.y0 = pix_y0; p.y1 = pix_y1;
                p.dx = dx; p.dy = dy; p.le = line_end; p.fe = frame_end;
                got_q.push_back(p);
                issue_cnt++;
                last_issue_cyc = cyc;
            end
            if (row_req === 1'b1) begin
                row_req_cnt++;
                got_rq.push_back(int'(row_idx));
                if (pix_en === 1'b1) viol++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
                busy_before_done = busy_last;
            end
            busy_last = busy;
            if (rst) occ = 0;
            else if (pix_en === 1'b1 && fifo_pop) occ = occ;
            else if (pix_en === 1'b1) occ++;
            else if (fifo_pop && occ > 0) occ--;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // reference model
    pix_t exp_q[$];
    int   exp_rq[$];

    task automatic build_expected(input int sw, input int sh, input int dw, input int dh,
                                  input int sx, input int sy);
        pix_t p;
        exp_q  = {};
        exp_rq = {};
        for (int r = 0; r < dh; r++) begin
            longint ay;
            int y0, y1, fy;
            ay = (longint'(r) * sy) % ACC_MOD;
            y0 = int'(ay >> SB);
            fy = int'(ay % (1 << SB));
            if (CLAMP && (y0 + 1 > sh - 1)) begin
                y1 = sh - 1;
                fy = 0;
            end else begin
                y1 = (y0 + 1) % (1 << CW);
            end
            exp_rq.push_back(y0);
            for (int c = 0; c < dw; c++) begin
                longint ax;
                int x0, x1, fx;
                ax = (longint'(c) * sx) % ACC_MOD;
                x0 = int'(ax >> SB);
                fx = int'(ax % (1 << SB));
                if (CLAMP && (x0 + 1 > sw - 1)) begin
                    x1 = sw - 1;
                    fx = 0;
                end else begin
                    x1 = (x0 + 1) % (1 << CW);
                end
                p.x0 = CW'(x0); p.x1 = CW'(x1); p.y0 = CW'(y0); p.y1 = CW'(y1);
                p.dx = SB'(fx); p.dy = SB'(fy);
                p.le = (c == dw - 1);
                p.fe = (c == dw - 1) && (r == dh - 1);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_cfg(input int sw, input int sh, input int dw, input int dh,
                           input int sx, input int sy);
        cfg_src_w  = CW'(sw);
        cfg_src_h  = CW'(sh);
        cfg_dst_w  = CW'(dw);
        cfg_dst_h  = CW'(dh);
        cfg_step_x = (CW+SB)'(sx);
        cfg_step_y = (CW+SB)'(sy);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string nm);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s done_timeout: no done within %0d cycles", nm, budget);
        end
    endtask

    task automatic check_frame(input string nm, input int pb, input int rb, input int vb);
        checks++;
        if (got_q.size() - pb != exp_q.size()) begin
            failures++;
            $display("FAIL %s issue_count got=%0d exp=%0d", nm, got_q.size() - pb, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (pb + i < got_q.size()) begin
                checks++;
                if (got_q[pb + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s pix[%0d] got=%h exp=%h", nm, i, got_q[pb + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (got_rq.size() - rb != exp_rq.size()) begin
            failures++;
            $display("FAIL %s row_req_count got=%0d exp=%0d", nm, got_rq.size() - rb, exp_rq.size());
        end
        for (int i = 0; i < exp_rq.size(); i++) begin
            if (rb + i < got_rq.size()) begin
                checks++;
                if (got_rq[rb + i] != exp_rq[i]) begin
                    failures++;
                    $display("FAIL %s row_idx[%0d] got=%0d exp=%0d", nm, i, got_rq[rb + i], exp_rq[i]);
                end
            end
        end
        checks++;
        if (viol != vb) begin
            failures++;
            $display("FAIL %s protocol_violations got=%0d exp=0", nm, viol - vb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge p_clk);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs_in_reset got=%h exp=0", all_out);
        end
        rst = 1'b0;
        repeat (2) tick();
        @(negedge p_clk);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs_idle got=%h exp=0", all_out);
        end
    endtask

    task automatic test_basic();
        int pb, rb, vb, d0;
        int x0e[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int x1e[8];
        int dxe[8];
        reset_dut();
        rdy_auto = 1'b0; rdy_manual = 1'b1; pop_rand = 1'b0; pop_manual = 1'b1;
        if (CLAMP) begin
            x1e = '{1, 1, 2, 2, 3, 3, 3, 3};
            dxe = '{0, 512, 0, 512, 0, 512, 0, 0};
        end else begin
            x1e = '{1, 1, 2, 2, 3, 3, 4, 4};
            dxe = '{0, 512, 0, 512, 0, 512, 0, 512};
        end
        build_expected(4, 4, 8, 8, 512, 512);
        pb = got_q.size(); rb = got_rq.size(); vb = viol; d0 = done_cnt;
        set_cfg(4, 4, 8, 8, 512, 512);
        pulse_start();
        wait_done(d0, 400, "basic");
        check_frame("basic", pb, rb, vb);
        for (int i = 0; i < 8; i++) begin
            if (pb + i < got_q.size()) begin
                checks++;
                if (got_q[pb + i].x0 != CW'(x0e[i]) || got_q[pb + i].x1 != CW'(x1e[i]) ||
                    got_q[pb + i].dx != SB'(dxe[i])) begin
                    failures++;
                    $display("FAIL basic_line0 col%0d got x0=%0d x1=%0d dx=%0d exp x0=%0d x1=%0d dx=%0d",
                             i, got_q[pb + i].x0, got_q[pb + i].x1, got_q[pb + i].dx,
                             x0e[i], x1e[i], dxe[i]);
                end
            end
        end
    endtask

    task automatic test_credits();
        int pb, rb, vb, d0, ib;
        reset_dut();
        rdy_auto = 1'b0; rdy_manual = 1'b1; pop_rand = 1'b0; pop_manual = 1'b0;
        build_expected(4, 4, 8, 8, 512, 512);
        pb = got_q.size(); rb = got_rq.size(); vb = viol; d0 = done_cnt; ib = issue_cnt;
        set_cfg(4, 4, 8, 8, 512, 512);
        pulse_start();
        repeat (40) tick();
        checks++;
        if (issue_cnt - ib != CR) begin
            failures++;
            $display("FAIL credits_stall issues got=%0d exp=%0d", issue_cnt - ib, CR);
        end
        pop_manual = 1'b1;
        tick();
        pop_manual = 1'b0;
        repeat (20) tick();
        checks++;
        if (issue_cnt - ib != CR + 1) begin
            failures++;
            $display("FAIL credits_one_pop issues got=%0d exp=%0d", issue_cnt - ib, CR + 1);
        end
        pop_manual = 1'b1;
        wait_done(d0, 400, "credits");
        check_frame("credits", pb, rb, vb);
    endtask

    task automatic test_row_wait();
        int pb, rb, vb, d0, rq0, ib, n, bad_busy;
        reset_dut();
        pop_rand = 1'b0; pop_manual = 1'b1; rdy_auto = 1'b0; rdy_manual = 1'b0;
        build_expected(4, 4, 2, 2, 2048, 2048);
        pb = got_q.size(); rb = got_rq.size(); vb = viol; d0 = done_cnt; rq0 = row_req_cnt;
        set_cfg(4, 4, 2, 2, 2048, 2048);
        pulse_start();
        n = 0;
        while (row_req_cnt == rq0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (row_req_cnt == rq0) begin
            failures++;
            $display("FAIL row_wait_req: no row_req within 10 cycles");
        end
        ib = issue_cnt;
        bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b1) bad_busy++;
        end
        checks++;
        if (issue_cnt != ib || bad_busy != 0) begin
            failures++;
            $display("FAIL row_wait_hold got issues=%0d busy_low=%0d exp issues=0 busy_low=0",
                     issue_cnt - ib, bad_busy);
        end
        rdy_manual = 1'b1;
        @(negedge p_clk);
        checks++;
        if (pix_en !== 1'b0) begin
            failures++;
            $display("FAIL row_wait_early pix_en got=%b exp=0", pix_en);
        end
        @(negedge p_clk);
        checks++;
        if (pix_en !== 1'b1) begin
            failures++;
            $display("FAIL row_wait_first_issue pix_en got=%b exp=1", pix_en);
        end
        wait_done(d0, 200, "row_wait");
        check_frame("row_wait", pb, rb, vb);
    endtask

    task automatic test_drain_done();
        int pb, rb, vb, d0;
        reset_dut();
        rdy_auto = 1'b0; rdy_manual = 1'b1; pop_rand = 1'b0; pop_manual = 1'b1;
        build_expected(4, 4, 2, 2, 2048, 2048);
        pb = got_q.size(); rb = got_rq.size(); vb = viol; d0 = done_cnt;
        set_cfg(4, 4, 2, 2, 2048, 2048);
        pulse_start();
        tick();
        set_cfg(8, 8, 8, 8, 256, 256);
        pulse_start();
        wait_done(d0, 200, "drain");
        checks++;
        if (done_cyc - last_issue_cyc != PL) begin
            failures++;
            $display("FAIL drain_latency got=%0d exp=%0d", done_cyc - last_issue_cyc, PL);
        end
        checks++;
        if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
            failures++;
            $display("FAIL drain_busy got at_done=%b before=%b exp at_done=0 before=1",
                     busy_at_done, busy_before_done);
        end
        repeat (10) tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL drain_done_count got=%0d exp=1", done_cnt - d0);
        end
        check_frame("drain", pb, rb, vb);
    endtask

    task automatic test_zero_size();
        int dws[2] = '{0, 5};
        int dhs[2] = '{5, 0};
        reset_dut();
        rdy_auto = 1'b0; rdy_manual = 1'b1; pop_rand = 1'b0; pop_manual = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int d0, rq0, ib;
            d0 = done_cnt; rq0 = row_req_cnt; ib = issue_cnt;
            set_cfg(4, 4, dws[k], dhs[k], 512, 512);
            pulse_start();
            @(negedge p_clk);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL zero_size%0d done=%b busy=%b exp done=1 busy=0", k, done, busy);
            end
            repeat (8) tick();
            checks++;
            if (done_cnt - d0 != 1 || row_req_cnt != rq0 || issue_cnt != ib) begin
                failures++;
                $display("FAIL zero_size%0d_quiet got done=%0d row_req=%0d issues=%0d exp 1 0 0",
                         k, done_cnt - d0, row_req_cnt - rq0, issue_cnt - ib);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int pb, rb, vb, d0, ib, n;
        reset_dut();
        rdy_auto = 1'b0; rdy_manual = 1'b1; pop_rand = 1'b0; pop_manual = 1'b1;
        set_cfg(4, 4, 8, 8, 512, 512);
        ib = issue_cnt; d0 = done_cnt;
        pulse_start();
        n = 0;
        while (issue_cnt - ib < 10 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (issue_cnt - ib < 10) begin
            failures++;
            $display("FAIL rst_mid_progress issues got=%0d exp>=10", issue_cnt - ib);
        end
        rst = 1'b1;
        @(negedge p_clk);
        @(negedge p_clk);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0", all_out);
        end
        tick();
        rst = 1'b0;
        repeat (10) tick();
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt - d0);
        end
        build_expected(4, 4, 8, 8, 512, 512);
        pb = got_q.size(); rb = got_rq.size(); vb = viol; d0 = done_cnt; ib = issue_cnt;
        pop_manual = 1'b0;
        pulse_start();
        repeat (40) tick();
        checks++;
        if (issue_cnt - ib != CR) begin
            failures++;
            $display("FAIL rst_mid_credit issues got=%0d exp=%0d", issue_cnt - ib, CR);
        end
        pop_manual = 1'b1;
        wait_done(d0, 400, "rst_mid");
        check_frame("rst_mid", pb, rb, vb);
    endtask

    task automatic test_random();
        reset_dut();
        rdy_auto = 1'b1; rdy_max = 4; pop_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int sw, sh, dw, dh, sx, sy, pb, rb, vb, d0;
            sw = $urandom_range(1, 16);
            sh = $urandom_range(1, 16);
            dw = $urandom_range(1, 10);
            dh = $urandom_range(1, 8);
            sx = $urandom_range(0, 4095);
            sy = $urandom_range(0, 4095);
            build_expected(sw, sh, dw, dh, sx, sy);
            pb = got_q.size(); rb = got_rq.size(); vb = viol; d0 = done_cnt;
            set_cfg(sw, sh, dw, dh, sx, sy);
            pulse_start();
            set_cfg($urandom_range(1, 16), $urandom_range(1, 16), $urandom_range(1, 10),
                    $urandom_range(1, 8), $urandom_range(0, 4095), $urandom_range(0, 4095));
            wait_done(d0, 3000, "random");
            check_frame("random", pb, rb, vb);
        end
        rdy_auto = 1'b0; pop_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credits();
        test_row_wait();
        test_drain_done();
        test_zero_size();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
